imem_arbiter: RTL and testbench

- Shares the single dual-read-port instruction BRAM between two requesters: the fetch unit (two-word read per cycle) and the program loader/debug port (single-word read or write).
- Fetch has default priority. A starvation counter guarantees the loader a slot after at most MAX_STARVE consecutive denials.
- The arbiter tags each issued access so the 1-cycle BRAM response is routed to its owner. It also discards stale fetch responses on redirect flush.
- Sits between fetch and imem.

---
 rtl/imem_arbiter.sv | 107 ++++++++++
 tb/tb_imem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : imem_arbiter
// Purpose  : Fetch/loader arbiter for the shared dual-read-port instruction BRAM.
// Revision : 1.0
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int MAX_STARVE  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   f_req,
    input  logic [ADDR_WIDTH-1:0]  f_addr0,
    input  logic [ADDR_WIDTH-1:0]  f_addr1,
    input  logic                   f_flush,
    output logic                   f_gnt,
    output logic                   f_rvalid,
    output logic [INSTR_WIDTH-1:0] f_rdata0,
    output logic [INSTR_WIDTH-1:0] f_rdata1,
    input  logic                   l_req,
    input  logic                   l_we,
    input  logic [ADDR_WIDTH-1:0]  l_addr,
    input  logic [INSTR_WIDTH-1:0] l_wdata,
    output logic                   l_gnt,
    output logic                   l_rvalid,
    output logic [INSTR_WIDTH-1:0] l_rdata,
    output logic                   imem_ren,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr0,
    output logic [ADDR_WIDTH-1:0]  imem_addr1,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    input  logic [INSTR_WIDTH-1:0] imem_rdata0,
    input  logic [INSTR_WIDTH-1:0] imem_rdata1
);

    localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t                 owner_q, owner_d;
    logic [3:0]             starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr0_q, addr1_q;
    logic [INSTR_WIDTH-1:0] wdata_q;
    logic                   w_starved;
    logic                   w_l_rd;
    logic                   w_l_wr;

    // Fetch wins by default; a loader that has waited MAX_STARVE cycles takes the slot.
    assign w_starved = (starve_cnt_q == c_max_starve);
    assign l_gnt     = !reset && l_req && (!f_req || w_starved);
    assign f_gnt     = !reset && f_req && !l_gnt;
    assign w_l_rd    = l_gnt && !l_we;
    assign w_l_wr    = l_gnt && l_we;

    assign imem_ren   = f_gnt || w_l_rd;
    assign imem_we    = w_l_wr;
    assign imem_addr0 = f_gnt ? f_addr0 : (l_gnt ? l_addr : addr0_q);
    assign imem_addr1 = f_gnt ? f_addr1 : (w_l_rd ? l_addr : addr1_q);
    assign imem_wdata = w_l_wr ? l_wdata : wdata_q;

    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt)
            owner_d = OWN_FETCH;
        else if (w_l_rd)
            owner_d = OWN_LOAD;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (l_gnt || !l_req)
            starve_cnt_d = 4'd0;
        else if (f_gnt && (starve_cnt_q != c_max_starve))
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= 4'd0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            wdata_q      <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            addr0_q      <= imem_addr0;
            addr1_q      <= imem_addr1;
            wdata_q      <= imem_wdata;
        end
    end

    // Response gating on reset drops a read that was in flight when reset hit.
    assign f_rvalid = !reset && (owner_q == OWN_FETCH) && !f_flush;
    assign f_rdata0 = imem_rdata0;
    assign f_rdata1 = imem_rdata1;
    assign l_rvalid = !reset && (owner_q == OWN_LOAD);
    assign l_rdata  = imem_rdata0;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_imem_arbiter
// Purpose  : Directed bench for imem_arbiter with a 1-cycle BRAM model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_flush, f_gnt, f_rvalid;
    logic [31:0] f_addr0, f_addr1, f_rdata0, f_rdata1;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        imem_ren, imem_we;
    logic [31:0] imem_addr0, imem_addr1, imem_wdata, imem_rdata0, imem_rdata1;

    logic [31:0] mem [0:15];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .MAX_STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr0(f_addr0), .f_addr1(f_addr1), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata0(f_rdata0), .f_rdata1(f_rdata1),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .imem_ren(imem_ren), .imem_we(imem_we),
        .imem_addr0(imem_addr0), .imem_addr1(imem_addr1), .imem_wdata(imem_wdata),
        .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1)
    );

    always @(posedge clk) begin
        if (imem_we)
            mem[imem_addr0[5:2]] <= imem_wdata;
        if (imem_ren) begin
            imem_rdata0 <= mem[imem_addr0[5:2]];
            imem_rdata1 <= mem[imem_addr1[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    initial begin
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        mem[4] = 32'h55555555; mem[5] = 32'h66666666;
        for (int i = 6; i < 16; i++) mem[i] = 32'h0;
        imem_rdata0 = '0; imem_rdata1 = '0;
        reset = 1'b1; f_req = 0; f_flush = 0; f_addr0 = 0; f_addr1 = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;

        // Reset state
        next_cycle(); mid_cycle();
        chk("rst_f_rvalid", 32'(f_rvalid), 0);
        chk("rst_l_rvalid", 32'(l_rvalid), 0);
        chk("rst_starve", 32'(dut.starve_cnt_q), 0);
        next_cycle(); reset = 1'b0;

        // Fetch only, three back-to-back two-word reads
        f_req = 1; f_addr0 = 32'h00; f_addr1 = 32'h04; mid_cycle();
        chk("fo_gnt0", 32'(f_gnt), 1);
        chk("fo_lgnt0", 32'(l_gnt), 0);
        chk("fo_ren0", 32'(imem_ren), 1);
        chk("fo_rvalid0", 32'(f_rvalid), 0);
        next_cycle(); f_addr0 = 32'h08; f_addr1 = 32'h0C; mid_cycle();
        chk("fo_gnt1", 32'(f_gnt), 1);
        chk("fo_rvalid1", 32'(f_rvalid), 1);
        chk("fo_rd0_1", f_rdata0, 32'h11111111);
        chk("fo_rd1_1", f_rdata1, 32'h22222222);
        next_cycle(); f_addr0 = 32'h10; f_addr1 = 32'h14; mid_cycle();
        chk("fo_rvalid2", 32'(f_rvalid), 1);
        chk("fo_rd0_2", f_rdata0, 32'h33333333);
        chk("fo_rd1_2", f_rdata1, 32'h44444444);
        next_cycle(); f_req = 0; mid_cycle();
        chk("fo_gnt_idle", 32'(f_gnt), 0);
        chk("fo_ren_idle", 32'(imem_ren), 0);
        chk("fo_addr_hold", imem_addr0, 32'h10);
        chk("fo_rvalid3", 32'(f_rvalid), 1);
        chk("fo_rd0_3", f_rdata0, 32'h55555555);
        chk("fo_rd1_3", f_rdata1, 32'h66666666);
        next_cycle(); mid_cycle();
        chk("fo_rvalid_end", 32'(f_rvalid), 0);

        // Loader starvation: denied 4 cycles, granted on the 5th
        next_cycle();
        f_req = 1; f_addr0 = 32'h00; f_addr1 = 32'h04;
        l_req = 1; l_we = 0; l_addr = 32'h08;
        for (int k = 0; k < 4; k++) begin
            mid_cycle();
            chk("st_fgnt", 32'(f_gnt), 1);
            chk("st_lgnt", 32'(l_gnt), 0);
            chk("st_cnt", 32'(dut.starve_cnt_q), 32'(k));
            next_cycle();
        end
        mid_cycle();
        chk("st_lgnt4", 32'(l_gnt), 1);
        chk("st_fgnt4", 32'(f_gnt), 0);
        chk("st_addr0", imem_addr0, 32'h08);
        chk("st_addr1", imem_addr1, 32'h08);
        next_cycle(); l_req = 0; mid_cycle();
        chk("st_lrvalid", 32'(l_rvalid), 1);
        chk("st_lrdata", l_rdata, 32'h33333333);
        chk("st_frvalid", 32'(f_rvalid), 0);
        chk("st_cnt_clr", 32'(dut.starve_cnt_q), 0);
        chk("st_fgnt5", 32'(f_gnt), 1);
        next_cycle(); f_req = 0; mid_cycle();
        chk("st_frvalid6", 32'(f_rvalid), 1);
        chk("st_frd0_6", f_rdata0, 32'h11111111);

        // Loader write, then fetch of the same word
        next_cycle(); l_req = 1; l_we = 1; l_addr = 32'h04; l_wdata = 32'hDEADBEEF; mid_cycle();
        chk("wr_lgnt", 32'(l_gnt), 1);
        chk("wr_we", 32'(imem_we), 1);
        chk("wr_ren", 32'(imem_ren), 0);
        chk("wr_addr0", imem_addr0, 32'h04);
        chk("wr_wdata", imem_wdata, 32'hDEADBEEF);
        next_cycle(); l_req = 0; l_we = 0;
        f_req = 1; f_addr0 = 32'h04; f_addr1 = 32'h08; mid_cycle();
        chk("wr_no_lrvalid", 32'(l_rvalid), 0);
        chk("wr_we_off", 32'(imem_we), 0);
        chk("wr_fgnt", 32'(f_gnt), 1);
        next_cycle(); f_req = 0; mid_cycle();
        chk("wr_frvalid", 32'(f_rvalid), 1);
        chk("wr_frd0", f_rdata0, 32'hDEADBEEF);
        chk("wr_frd1", f_rdata1, 32'h33333333);

        // Flush kills the stale response but not the redirected fetch
        next_cycle(); f_req = 1; f_addr0 = 32'h00; f_addr1 = 32'h04; mid_cycle();
        chk("fl_gnt0", 32'(f_gnt), 1);
        next_cycle(); f_flush = 1; f_addr0 = 32'h08; f_addr1 = 32'h0C; mid_cycle();
        chk("fl_rvalid_kill", 32'(f_rvalid), 0);
        chk("fl_gnt1", 32'(f_gnt), 1);
        next_cycle(); f_flush = 0; f_req = 0; mid_cycle();
        chk("fl_rvalid_new", 32'(f_rvalid), 1);
        chk("fl_rd0", f_rdata0, 32'h33333333);
        chk("fl_rd1", f_rdata1, 32'h44444444);

        // Flush while the loader owns the response has no effect
        next_cycle(); l_req = 1; l_we = 0; l_addr = 32'h00; mid_cycle();
        chk("fl_lgnt", 32'(l_gnt), 1);
        next_cycle(); l_req = 0; f_flush = 1; mid_cycle();
        chk("fl_lrvalid", 32'(l_rvalid), 1);
        chk("fl_lrdata", l_rdata, 32'h11111111);
        chk("fl_frvalid_l", 32'(f_rvalid), 0);

        // Reset while a loader read is in flight
        next_cycle(); f_flush = 0; l_req = 1; l_addr = 32'h0C; mid_cycle();
        chk("rm_lgnt", 32'(l_gnt), 1);
        next_cycle(); reset = 1; f_req = 1; mid_cycle();
        chk("rm_lrvalid1", 32'(l_rvalid), 0);
        chk("rm_lgnt_rst", 32'(l_gnt), 0);
        chk("rm_fgnt_rst", 32'(f_gnt), 0);
        chk("rm_ren_rst", 32'(imem_ren), 0);
        next_cycle(); reset = 0; l_req = 0; f_req = 0; mid_cycle();
        chk("rm_lrvalid2", 32'(l_rvalid), 0);
        chk("rm_frvalid2", 32'(f_rvalid), 0);
        chk("rm_starve", 32'(dut.starve_cnt_q), 0);

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
